alarm_clock_ctrl: RTL and testbench

//   Timekeeping and alarm controller that sequences the 1 Hz seconds prescaler.

---
 rtl/alarm_clock_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_alarm_clock_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock_ctrl.sv
// Alarm clock controller: keeps HH:MM:SS from the 1 Hz tick, runs the set-mode
// FSM from the button pulses and the ring/snooze FSM that drives the buzzer.
module alarm_clock_ctrl #(
    parameter int ALARM_RST_HR = 6,
    parameter int SNOOZE_MIN   = 5,
    parameter int RING_MAX_SEC = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_snooze,
    input  logic       alarm_en,
    output logic       cnt_en,
    output logic [4:0] disp_hh,
    output logic [5:0] disp_mm,
    output logic [5:0] disp_ss,
    output logic [2:0] mode,
    output logic       alarm_ring
);

    localparam int SNZ_W = $clog2(SNOOZE_MIN * 60 + 1);
    localparam logic [SNZ_W-1:0] SNZ_LOAD  = SNZ_W'(SNOOZE_MIN * 60);
    localparam logic [7:0]       RING_LAST = 8'(RING_MAX_SEC - 1);

    typedef enum logic [2:0] {
        M_RUN      = 3'd0,
        M_SET_HR   = 3'd1,
        M_SET_MIN  = 3'd2,
        M_SET_AHR  = 3'd3,
        M_SET_AMIN = 3'd4
    } mode_t;

    typedef enum logic [1:0] {
        R_IDLE    = 2'd0,
        R_RINGING = 2'd1,
        R_SNOOZE  = 2'd2
    } ring_t;

    mode_t            mode_q, mode_d;
    ring_t            ring_q, ring_d;
    logic [4:0]       hh_q, hh_d, ahh_q, ahh_d;
    logic [5:0]       mm_q, mm_d, ss_q, ss_d, amm_q, amm_d;
    logic [7:0]       ring_cnt_q, ring_cnt_d;
    logic [SNZ_W-1:0] snz_q, snz_d;
    logic             ticked_q;

    logic time_runs;
    logic run_tick;
    logic step_mode;
    logic dismiss;
    logic match;

    always_comb begin
        time_runs = (mode_q == M_RUN) || (mode_q == M_SET_AHR) || (mode_q == M_SET_AMIN);
        run_tick  = sec_tick && time_runs;
        // A mode press while the alarm is active only silences it.
        step_mode = btn_mode && (ring_q == R_IDLE);
        dismiss   = btn_mode && (ring_q != R_IDLE);
        match     = ticked_q && alarm_en && (hh_q == ahh_q) && (mm_q == amm_q)
                    && (ss_q == 6'd0);
    end

    always_comb begin
        mode_d = mode_q;
        if (step_mode) begin
            case (mode_q)
                M_RUN:      mode_d = M_SET_HR;
                M_SET_HR:   mode_d = M_SET_MIN;
                M_SET_MIN:  mode_d = M_SET_AHR;
                M_SET_AHR:  mode_d = M_SET_AMIN;
                default:    mode_d = M_RUN;
            endcase
        end
    end

    always_comb begin
        hh_d  = hh_q;
        mm_d  = mm_q;
        ss_d  = ss_q;
        ahh_d = ahh_q;
        amm_d = amm_q;
        if (run_tick) begin
            if (ss_q == 6'd59) begin
                ss_d = 6'd0;
                if (mm_q == 6'd59) begin
                    mm_d = 6'd0;
                    hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
                end else begin
                    mm_d = mm_q + 6'd1;
                end
            end else begin
                ss_d = ss_q + 6'd1;
            end
        end
        if (step_mode && (mode_q == M_RUN)) begin
            ss_d = 6'd0;
        end
        // Field increments never carry; a simultaneous mode press drops them.
        if (btn_inc && !btn_mode) begin
            case (mode_q)
                M_SET_HR:   hh_d  = (hh_q  == 5'd23) ? 5'd0 : hh_q  + 5'd1;
                M_SET_MIN:  mm_d  = (mm_q  == 6'd59) ? 6'd0 : mm_q  + 6'd1;
                M_SET_AHR:  ahh_d = (ahh_q == 5'd23) ? 5'd0 : ahh_q + 5'd1;
                M_SET_AMIN: amm_d = (amm_q == 6'd59) ? 6'd0 : amm_q + 6'd1;
                default:    ;
            endcase
        end
    end

    always_comb begin
        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
        snz_d      = snz_q;
        if (!alarm_en) begin
            ring_d = R_IDLE;
        end else begin
            case (ring_q)
                R_IDLE: begin
                    if (match) begin
                        ring_d     = R_RINGING;
                        ring_cnt_d = 8'd0;
                    end
                end
                R_RINGING: begin
                    if (dismiss) begin
                        ring_d = R_IDLE;
                    end else if (btn_snooze) begin
                        ring_d = R_SNOOZE;
                        snz_d  = SNZ_LOAD;
                    end else if (run_tick) begin
                        if (ring_cnt_q == RING_LAST) begin
                            ring_d = R_IDLE;
                        end else begin
                            ring_cnt_d = ring_cnt_q + 8'd1;
                        end
                    end
                end
                R_SNOOZE: begin
                    if (dismiss) begin
                        ring_d = R_IDLE;
                    end else if (run_tick) begin
                        if (snz_q <= SNZ_W'(1)) begin
                            snz_d      = '0;
                            ring_d     = R_RINGING;
                            ring_cnt_d = 8'd0;
                        end else begin
                            snz_d = snz_q - SNZ_W'(1);
                        end
                    end
                end
                default: ring_d = R_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next-state values so they track the state exactly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q     <= M_RUN;
            ring_q     <= R_IDLE;
            hh_q       <= 5'd0;
            mm_q       <= 6'd0;
            ss_q       <= 6'd0;
            ahh_q      <= 5'(ALARM_RST_HR);
            amm_q      <= 6'd0;
            ring_cnt_q <= 8'd0;
            snz_q      <= '0;
            ticked_q   <= 1'b0;
            cnt_en     <= 1'b1;
            disp_hh    <= 5'd0;
            disp_mm    <= 6'd0;
            disp_ss    <= 6'd0;
            mode       <= 3'd0;
            alarm_ring <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            ring_q     <= ring_d;
            hh_q       <= hh_d;
            mm_q       <= mm_d;
            ss_q       <= ss_d;
            ahh_q      <= ahh_d;
            amm_q      <= amm_d;
            ring_cnt_q <= ring_cnt_d;
            snz_q      <= snz_d;
            ticked_q   <= run_tick;
            cnt_en     <= (mode_d != M_SET_HR) && (mode_d != M_SET_MIN);
            disp_hh    <= ((mode_d == M_SET_AHR) || (mode_d == M_SET_AMIN)) ? ahh_d : hh_d;
            disp_mm    <= ((mode_d == M_SET_AHR) || (mode_d == M_SET_AMIN)) ? amm_d : mm_d;
            disp_ss    <= ss_d;
            mode       <= mode_d;
            alarm_ring <= (ring_d == R_RINGING);
        end
    end

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Directed bench for alarm_clock_ctrl: timekeeping, set modes, alarm ring/snooze
// and reset abort, with hand-computed expectations.
module tb_alarm_clock_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sec_tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_snooze = 1'b0;
    logic       alarm_en = 1'b0;
    logic       cnt_en;
    logic [4:0] disp_hh;
    logic [5:0] disp_mm;
    logic [5:0] disp_ss;
    logic [2:0] mode;
    logic       alarm_ring;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alarm_clock_ctrl #(
        .ALARM_RST_HR(6),
        .SNOOZE_MIN(5),
        .RING_MAX_SEC(60)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sec_tick(sec_tick),
        .btn_mode(btn_mode),
        .btn_inc(btn_inc),
        .btn_snooze(btn_snooze),
        .alarm_en(alarm_en),
        .cnt_en(cnt_en),
        .disp_hh(disp_hh),
        .disp_mm(disp_mm),
        .disp_ss(disp_ss),
        .mode(mode),
        .alarm_ring(alarm_ring)
    );

    // One-cycle pulse: driven at a falling edge, sampled by the next rising edge.
    task automatic applyStimulus(input logic t, input logic m, input logic i, input logic s);
        @(negedge clk);
        sec_tick   = t;
        btn_mode   = m;
        btn_inc    = i;
        btn_snooze = s;
        @(negedge clk);
        sec_tick   = 1'b0;
        btn_mode   = 1'b0;
        btn_inc    = 1'b0;
        btn_snooze = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkDisp(input string tag, input int h, input int m, input int s);
        checkOutput({tag, "_hh"}, 32'(disp_hh), 32'(h));
        checkOutput({tag, "_mm"}, 32'(disp_mm), 32'(m));
        checkOutput({tag, "_ss"}, 32'(disp_ss), 32'(s));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic modes(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic incs(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic checkResetState(input string tag);
        checkDisp(tag, 0, 0, 0);
        checkOutput({tag, "_mode"}, 32'(mode), 32'd0);
        checkOutput({tag, "_cnt_en"}, 32'(cnt_en), 32'd1);
        checkOutput({tag, "_ring"}, 32'(alarm_ring), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        checkResetState("reset");

        // 3661 seconds = 1 h + 1 min + 1 s
        ticks(3661);
        checkDisp("run_3661", 1, 1, 1);
        incs(1);
        checkDisp("inc_in_run", 1, 1, 1);

        doReset();
        checkResetState("reset2");

        modes(1);
        checkOutput("set_hr_mode", 32'(mode), 32'd1);
        checkOutput("set_hr_cnt_en", 32'(cnt_en), 32'd0);
        incs(25);
        checkDisp("set_hr_25inc", 1, 0, 0);
        ticks(5);
        checkDisp("set_hr_ticks_ignored", 1, 0, 0);
        incs(22);
        checkOutput("set_hr_23", 32'(disp_hh), 32'd23);
        modes(1);
        checkOutput("set_min_mode", 32'(mode), 32'd2);
        checkOutput("set_min_cnt_en", 32'(cnt_en), 32'd0);
        incs(59);
        checkOutput("set_min_59", 32'(disp_mm), 32'd59);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("mode_inc_mode", 32'(mode), 32'd3);
        checkOutput("mode_inc_ahh", 32'(disp_hh), 32'd6);
        checkOutput("mode_inc_amm", 32'(disp_mm), 32'd0);
        checkOutput("set_ahr_cnt_en", 32'(cnt_en), 32'd1);
        modes(2);
        checkOutput("back_run_mode", 32'(mode), 32'd0);
        checkOutput("back_run_cnt_en", 32'(cnt_en), 32'd1);
        checkDisp("back_run_time", 23, 59, 0);
        ticks(59);
        checkDisp("pre_wrap", 23, 59, 59);
        ticks(1);
        checkDisp("wrap", 0, 0, 0);
        @(negedge clk);
        checkDisp("wrap_hold", 0, 0, 0);

        // Build 05:59:59 with the alarm at its 06:00 reset value.
        modes(1);
        incs(5);
        modes(1);
        incs(59);
        modes(3);
        checkDisp("pre_alarm_set", 5, 59, 0);
        alarm_en = 1'b1;
        ticks(59);
        checkDisp("pre_alarm", 5, 59, 59);
        checkOutput("pre_alarm_ring", 32'(alarm_ring), 32'd0);
        ticks(1);
        checkDisp("alarm_time", 6, 0, 0);
        checkOutput("alarm_ring_lag", 32'(alarm_ring), 32'd0);
        @(negedge clk);
        checkOutput("alarm_ring_on", 32'(alarm_ring), 32'd1);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("snooze_ring_off", 32'(alarm_ring), 32'd0);
        ticks(299);
        checkOutput("snooze_299", 32'(alarm_ring), 32'd0);
        ticks(1);
        checkOutput("snooze_300", 32'(alarm_ring), 32'd1);
        checkDisp("snooze_end_time", 6, 5, 0);
        ticks(59);
        checkOutput("ring_59", 32'(alarm_ring), 32'd1);
        ticks(1);
        checkOutput("ring_timeout", 32'(alarm_ring), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("snooze_idle_ignored", 32'(alarm_ring), 32'd0);

        // Alarm to 06:07, dismiss with the mode button.
        modes(4);
        incs(7);
        checkOutput("set_amin_mode", 32'(mode), 32'd4);
        checkOutput("set_amin_hh", 32'(disp_hh), 32'd6);
        checkOutput("set_amin_mm", 32'(disp_mm), 32'd7);
        modes(1);
        checkDisp("alarm2_pre", 6, 6, 0);
        ticks(60);
        checkOutput("alarm2_lag", 32'(alarm_ring), 32'd0);
        @(negedge clk);
        checkOutput("alarm2_on", 32'(alarm_ring), 32'd1);
        modes(1);
        checkOutput("dismiss_ring", 32'(alarm_ring), 32'd0);
        checkOutput("dismiss_mode", 32'(mode), 32'd0);

        // Alarm to 06:08, cancel with alarm_en.
        modes(4);
        incs(1);
        modes(1);
        ticks(60);
        @(negedge clk);
        checkOutput("alarm3_on", 32'(alarm_ring), 32'd1);
        alarm_en = 1'b0;
        @(negedge clk);
        checkOutput("alarm_en_off", 32'(alarm_ring), 32'd0);
        alarm_en = 1'b1;

        // Alarm to 06:09 while sitting in SET_AMIN, snooze, then reset.
        modes(4);
        incs(1);
        ticks(60);
        @(negedge clk);
        checkOutput("alarm4_on", 32'(alarm_ring), 32'd1);
        checkOutput("alarm4_mode", 32'(mode), 32'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("alarm4_snooze", 32'(alarm_ring), 32'd0);
        ticks(10);
        doReset();
        checkResetState("reset_mid_snooze");
        modes(3);
        checkOutput("reset_alarm_hh", 32'(disp_hh), 32'd6);
        checkOutput("reset_alarm_mm", 32'(disp_mm), 32'd0);
        modes(2);
        ticks(300);
        checkOutput("snooze_aborted", 32'(alarm_ring), 32'd0);
        checkDisp("after_reset_run", 0, 5, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
